// File: rtl/csr_timer_pkg.sv
// rtl/csr_timer_pkg.sv - register select codes and CFG field positions for the timer bank
package csr_timer_pkg;

   localparam logic [1:0] WR_SEL_CFG = 2'd0;
   localparam logic [1:0] WR_SEL_CLR = 2'd1;

   localparam logic [1:0] RD_SEL_CFG = 2'd0;
   localparam logic [1:0] RD_SEL_VAL = 2'd1;
   localparam logic [1:0] RD_SEL_CLR = 2'd2;

   localparam int CFG_EN_BIT       = 0;
   localparam int CFG_PERIODIC_BIT = 1;
   localparam int CFG_INITV_LSB    = 2;

endpackage

// File: rtl/csr_timer_ch.sv
// rtl/csr_timer_ch.sv - one countdown timer channel: cfg register, counter and pending flag
module csr_timer_ch
   import csr_timer_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cfg_we,
   input  logic             clr_we,
   input  logic [CNT_W-1:0] wr_data,
   input  logic [CNT_W-1:0] wr_mask,
   output logic [CNT_W-1:0] cfg,
   output logic [CNT_W-1:0] cnt,
   output logic             pend
);

   logic [CNT_W-1:0] next_cfg;
   logic [CNT_W-1:0] write_reload;
   logic [CNT_W-1:0] cur_reload;
   logic             expired;

   always_comb begin
      next_cfg     = (wr_mask & wr_data) | (~wr_mask & cfg);
      write_reload = {next_cfg[CNT_W-1:CFG_INITV_LSB], {CFG_INITV_LSB{1'b0}}};
      cur_reload   = {cfg[CNT_W-1:CFG_INITV_LSB], {CFG_INITV_LSB{1'b0}}};
      expired      = cfg[CFG_EN_BIT] && (cnt == '0);
   end

   // All-ones is the parked state of a finished one-shot; it never counts out of it.
   always_ff @(posedge clk) begin
      if (reset) begin
         cfg  <= '0;
         cnt  <= '1;
         pend <= 1'b0;
      end else begin
         if (cfg_we) begin
            cfg <= next_cfg;
            if (next_cfg[CFG_EN_BIT])
               cnt <= write_reload;
         end else if (cfg[CFG_EN_BIT] && (cnt != '1)) begin
            if ((cnt == '0) && cfg[CFG_PERIODIC_BIT])
               cnt <= cur_reload;
            else
               cnt <= cnt - CNT_W'(1);
         end

         if (expired)
            pend <= 1'b1;
         else if (clr_we)
            pend <= 1'b0;
      end
   end

endmodule

// File: rtl/csr_timer_bank.sv
// rtl/csr_timer_bank.sv - bank of countdown timers with masked register writes, read mux and cycle counter
module csr_timer_bank
   import csr_timer_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 32,
   parameter int CH_W   = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [CH_W-1:0]   wr_ch,
   input  logic [1:0]        wr_sel,
   input  logic [CNT_W-1:0]  wr_data,
   input  logic [CNT_W-1:0]  wr_mask,
   input  logic [CH_W-1:0]   rd_ch,
   input  logic [1:0]        rd_sel,
   output logic [CNT_W-1:0]  rd_data,
   input  logic [NUM_CH-1:0] irq_en,
   output logic [NUM_CH-1:0] irq_pend,
   output logic              irq,
   output logic [63:0]       stable_cnt
);

   logic [CNT_W-1:0]  cfg_q [NUM_CH];
   logic [CNT_W-1:0]  cnt_q [NUM_CH];
   logic [NUM_CH-1:0] pend_q;
   logic [CNT_W-1:0]  rd_cfg;
   logic [CNT_W-1:0]  rd_cnt;

   // Channel indices at or above NUM_CH match no instance, so such writes fall away.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic hit;
      assign hit = wr_en && (wr_ch == CH_W'(i));

      csr_timer_ch #(.CNT_W(CNT_W)) u_ch (
         .clk     (clk),
         .reset   (reset),
         .cfg_we  (hit && (wr_sel == WR_SEL_CFG)),
         .clr_we  (hit && (wr_sel == WR_SEL_CLR) && wr_mask[0] && wr_data[0]),
         .wr_data (wr_data),
         .wr_mask (wr_mask),
         .cfg     (cfg_q[i]),
         .cnt     (cnt_q[i]),
         .pend    (pend_q[i])
      );
   end

   assign irq_pend = pend_q;
   assign irq      = |(pend_q & irq_en);

   always_comb begin
      rd_cfg = '0;
      rd_cnt = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (rd_ch == CH_W'(i)) begin
            rd_cfg = cfg_q[i];
            rd_cnt = cnt_q[i];
         end
      end
      case (rd_sel)
         RD_SEL_CFG: rd_data = rd_cfg;
         RD_SEL_VAL: rd_data = rd_cnt;
         RD_SEL_CLR: rd_data = '0;
         default:    rd_data = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)
         stable_cnt <= 64'd0;
      else
         stable_cnt <= stable_cnt + 64'd1;
   end

endmodule

// File: tb/tb_csr_timer_bank.sv
// tb/tb_csr_timer_bank.sv - self-checking bench for csr_timer_bank
module tb_csr_timer_bank;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        wr_en = 1'b0;
   logic [1:0]  wr_ch = '0;
   logic [1:0]  wr_sel = '0;
   logic [31:0] wr_data = '0;
   logic [31:0] wr_mask = '0;
   logic [1:0]  rd_ch = '0;
   logic [1:0]  rd_sel = '0;
   logic [31:0] rd_data;
   logic [3:0]  irq_en = '0;
   logic [3:0]  irq_pend;
   logic        irq;
   logic [63:0] stable_cnt;

   logic        b_wr_en = 1'b0;
   logic [1:0]  b_wr_ch = '0;
   logic [1:0]  b_wr_sel = '0;
   logic [7:0]  b_wr_data = '0;
   logic [7:0]  b_wr_mask = '0;
   logic [1:0]  b_rd_ch = '0;
   logic [1:0]  b_rd_sel = '0;
   logic [7:0]  b_rd_data;
   logic [2:0]  b_irq_en = '0;
   logic [2:0]  b_irq_pend;
   logic        b_irq;
   logic [63:0] b_stable_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   csr_timer_bank #(.NUM_CH(4), .CNT_W(32), .CH_W(2)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_ch(wr_ch), .wr_sel(wr_sel),
      .wr_data(wr_data), .wr_mask(wr_mask), .rd_ch(rd_ch), .rd_sel(rd_sel),
      .rd_data(rd_data), .irq_en(irq_en), .irq_pend(irq_pend), .irq(irq),
      .stable_cnt(stable_cnt)
   );

   csr_timer_bank #(.NUM_CH(3), .CNT_W(8), .CH_W(2)) dut_b (
      .clk(clk), .reset(reset), .wr_en(b_wr_en), .wr_ch(b_wr_ch), .wr_sel(b_wr_sel),
      .wr_data(b_wr_data), .wr_mask(b_wr_mask), .rd_ch(b_rd_ch), .rd_sel(b_rd_sel),
      .rd_data(b_rd_data), .irq_en(b_irq_en), .irq_pend(b_irq_pend), .irq(b_irq),
      .stable_cnt(b_stable_cnt)
   );

   always #5 clk = ~clk;

   // Reference model of the 4-channel, 32-bit instance, advanced once per clock.
   logic [31:0] m_cfg [4];
   logic [31:0] m_cnt [4];
   logic [3:0]  m_pend;
   logic [63:0] m_stable;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      logic [31:0] ncfg [4];
      logic [31:0] ncnt [4];
      logic [3:0]  npend;
      logic [31:0] merged;
      bit          is_cfg, is_clr, fired;
      for (int ch = 0; ch < 4; ch++) begin
         ncfg[ch] = m_cfg[ch];
         ncnt[ch] = m_cnt[ch];
         npend[ch] = m_pend[ch];
         is_cfg = wr_en && wr_sel == 2'd0 && wr_ch == 2'(ch);
         is_clr = wr_en && wr_sel == 2'd1 && wr_ch == 2'(ch) && wr_mask[0] && wr_data[0];
         fired  = m_cfg[ch][0] && m_cnt[ch] == 32'd0;
         if (is_cfg) begin
            merged   = (wr_data & wr_mask) | (m_cfg[ch] & ~wr_mask);
            ncfg[ch] = merged;
            if (merged[0]) ncnt[ch] = merged & ~32'd3;
         end else if (m_cfg[ch][0] && m_cnt[ch] != 32'hFFFF_FFFF) begin
            if (m_cnt[ch] == 32'd0 && m_cfg[ch][1]) ncnt[ch] = m_cfg[ch] & ~32'd3;
            else ncnt[ch] = m_cnt[ch] - 32'd1;
         end
         if (fired) npend[ch] = 1'b1;
         else if (is_clr) npend[ch] = 1'b0;
      end
      @(posedge clk);
      #1;
      if (reset) begin
         for (int ch = 0; ch < 4; ch++) begin
            m_cfg[ch] = 32'd0;
            m_cnt[ch] = 32'hFFFF_FFFF;
         end
         m_pend = '0;
         m_stable = 64'd0;
      end else begin
         for (int ch = 0; ch < 4; ch++) begin
            m_cfg[ch] = ncfg[ch];
            m_cnt[ch] = ncnt[ch];
         end
         m_pend = npend;
         m_stable = m_stable + 64'd1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      wr_en = 1'b0;
      b_wr_en = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic wr(input int ch, input int sel, input logic [31:0] data, input logic [31:0] mask);
      wr_en = 1'b1; wr_ch = 2'(ch); wr_sel = 2'(sel); wr_data = data; wr_mask = mask;
      step();
      wr_en = 1'b0;
   endtask

   task automatic rd_chk(input string name, input int ch, input int sel, input logic [31:0] exp);
      rd_ch = 2'(ch); rd_sel = 2'(sel);
      #1;
      chk(name, 64'(rd_data), 64'(exp));
   endtask

   task automatic b_rd_chk(input string name, input int ch, input int sel, input logic [7:0] exp);
      b_rd_ch = 2'(ch); b_rd_sel = 2'(sel);
      #1;
      chk(name, 64'(b_rd_data), 64'(exp));
   endtask

   typedef struct {
      bit          we;
      logic [1:0]  ch;
      logic [1:0]  sel;
      logic [31:0] data;
      logic [31:0] mask;
      logic [1:0]  rch;
      logic [1:0]  rsel;
      logic [31:0] exp_rd;
      logic [3:0]  exp_pend;
   } vec_t;

   vec_t tv [12];
   int   exp_seq [10] = '{3, 2, 1, 0, 4, 3, 2, 1, 0, 4};
   int   exp_irq [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1};

   initial begin
      tv[0]  = '{1'b1, 2'd3, 2'd0, 32'h11,        32'hFFFF_FFFF, 2'd3, 2'd0, 32'h11,        4'h0};
      tv[1]  = '{1'b1, 2'd3, 2'd0, 32'h0,         32'h1,         2'd3, 2'd0, 32'h10,        4'h0};
      tv[2]  = '{1'b0, 2'd0, 2'd0, 32'h0,         32'h0,         2'd3, 2'd1, 32'h10,        4'h0};
      tv[3]  = '{1'b0, 2'd0, 2'd0, 32'h0,         32'h0,         2'd3, 2'd1, 32'h10,        4'h0};
      tv[4]  = '{1'b1, 2'd2, 2'd0, 32'hFFFF_FFFF, 32'h0,         2'd2, 2'd0, 32'h0,         4'h0};
      tv[5]  = '{1'b1, 2'd0, 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd0, 2'd0, 32'h0,         4'h0};
      tv[6]  = '{1'b1, 2'd0, 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd3, 2'd2, 32'h0,         4'h0};
      tv[7]  = '{1'b0, 2'd0, 2'd0, 32'h0,         32'h0,         2'd3, 2'd3, 32'h0,         4'h0};
      tv[8]  = '{1'b0, 2'd0, 2'd0, 32'h0,         32'h0,         2'd0, 2'd1, 32'hFFFF_FFFF, 4'h0};
      tv[9]  = '{1'b1, 2'd1, 2'd0, 32'h9,         32'hFFFF_FFFF, 2'd1, 2'd1, 32'h8,         4'h0};
      tv[10] = '{1'b0, 2'd0, 2'd0, 32'h0,         32'h0,         2'd1, 2'd0, 32'h9,         4'h0};
      tv[11] = '{1'b1, 2'd1, 2'd1, 32'h1,         32'h1,         2'd1, 2'd1, 32'h6,         4'h0};

      #1;
      do_reset();
      rd_chk("rst_cfg", 0, 0, 32'h0);
      rd_chk("rst_val", 2, 1, 32'hFFFF_FFFF);
      chk("rst_pend", 64'(irq_pend), 64'h0);
      chk("rst_stable", stable_cnt, 64'd0);
      chk("rst_irq", 64'(irq), 64'd0);

      for (int i = 0; i < 12; i++) begin
         wr_en = tv[i].we; wr_ch = tv[i].ch; wr_sel = tv[i].sel;
         wr_data = tv[i].data; wr_mask = tv[i].mask;
         step();
         wr_en = 1'b0;
         rd_chk($sformatf("vec%0d_rd", i), int'(tv[i].rch), int'(tv[i].rsel), tv[i].exp_rd);
         chk($sformatf("vec%0d_pend", i), 64'(irq_pend), 64'(tv[i].exp_pend));
      end

      // A pending write must not show on the read port before the edge.
      wr_en = 1'b1; wr_ch = 2'd1; wr_sel = 2'd0; wr_data = 32'h0; wr_mask = 32'hFFFF_FFFF;
      rd_chk("nobypass_pre", 1, 0, 32'h9);
      step();
      wr_en = 1'b0;
      rd_chk("nobypass_post", 1, 0, 32'h0);

      // One-shot on ch1
      do_reset();
      wr(1, 0, 32'h9, 32'hFFFF_FFFF);
      rd_chk("oneshot_first", 1, 1, 32'h8);
      for (int k = 1; k <= 9; k++) begin
         step();
         if (k == 8) chk("oneshot_pend_early", 64'(irq_pend[1]), 64'd0);
      end
      chk("oneshot_pend", 64'(irq_pend[1]), 64'd1);
      rd_chk("oneshot_wrap", 1, 1, 32'hFFFF_FFFF);
      for (int k = 0; k < 3; k++) step();
      rd_chk("oneshot_parked", 1, 1, 32'hFFFF_FFFF);
      chk("oneshot_pend_hold", 64'(irq_pend[1]), 64'd1);

      // Periodic on ch0 with interrupt enabled
      do_reset();
      irq_en = 4'h1;
      wr(0, 0, 32'h7, 32'hFFFF_FFFF);
      rd_chk("per_load", 0, 1, 32'h4);
      for (int k = 0; k < 10; k++) begin
         step();
         rd_chk($sformatf("per_val%0d", k), 0, 1, 32'(exp_seq[k]));
         chk($sformatf("per_irq%0d", k), 64'(irq), 64'(exp_irq[k]));
      end
      wr(0, 1, 32'h1, 32'h1);
      chk("per_clr_irq", 64'(irq), 64'd0);
      for (int k = 0; k < 3; k++) step();
      chk("per_no_pend", 64'(irq_pend[0]), 64'd0);
      step();
      chk("per_recur", 64'(irq_pend[0]), 64'd1);
      irq_en = 4'h0;
      #1 chk("irq_masked", 64'(irq), 64'd0);
      irq_en = 4'h1;
      #1 chk("irq_unmasked", 64'(irq), 64'd1);

      // Clear racing an expiry on ch2
      do_reset();
      wr(2, 0, 32'h7, 32'hFFFF_FFFF);
      for (int k = 0; k < 4; k++) step();
      rd_chk("race_at_zero", 2, 1, 32'h0);
      wr(2, 1, 32'h1, 32'h1);
      chk("race_set_wins", 64'(irq_pend[2]), 64'd1);
      wr(2, 1, 32'h1, 32'h1);
      chk("race_clr_later", 64'(irq_pend[2]), 64'd0);
      for (int k = 0; k < 3; k++) step();
      chk("race_quiet", 64'(irq_pend[2]), 64'd0);
      step();
      chk("race_recur", 64'(irq_pend[2]), 64'd1);

      // INITV=0 periodic on ch3 expires every cycle; disabling keeps pending
      wr(3, 0, 32'h3, 32'hFFFF_FFFF);
      step();
      chk("zero_pend", 64'(irq_pend[3]), 64'd1);
      wr(3, 1, 32'h1, 32'h1);
      wr(3, 1, 32'h1, 32'h1);
      chk("zero_clr_loses", 64'(irq_pend[3]), 64'd1);
      rd_chk("zero_val", 3, 1, 32'h0);
      wr(3, 0, 32'h0, 32'h1);
      step();
      chk("dis_keeps_pend", 64'(irq_pend[3]), 64'd1);
      wr(3, 1, 32'h1, 32'h1);
      chk("dis_clr", 64'(irq_pend[3]), 64'd0);

      // Reset in the middle of a count with a same-cycle write
      do_reset();
      irq_en = 4'hF;
      wr(1, 0, 32'h9, 32'hFFFF_FFFF);
      for (int k = 0; k < 3; k++) step();
      rd_chk("mid_val5", 1, 1, 32'h5);
      reset = 1'b1;
      wr_en = 1'b1; wr_ch = 2'd1; wr_sel = 2'd0; wr_data = 32'hFFFF_FFFF; wr_mask = 32'hFFFF_FFFF;
      step();
      wr_en = 1'b0;
      rd_chk("mid_cfg", 1, 0, 32'h0);
      rd_chk("mid_val", 1, 1, 32'hFFFF_FFFF);
      chk("mid_pend", 64'(irq_pend), 64'h0);
      chk("mid_stable", stable_cnt, 64'd0);
      chk("mid_irq", 64'(irq), 64'd0);
      reset = 1'b0;
      step();
      chk("mid_stable1", stable_cnt, 64'd1);

      // Out-of-range channel on the 3-channel instance
      b_wr_en = 1'b1; b_wr_ch = 2'd3; b_wr_sel = 2'd0; b_wr_data = 8'hFF; b_wr_mask = 8'hFF;
      step();
      b_wr_en = 1'b0;
      for (int ch = 0; ch < 3; ch++) begin
         b_rd_chk($sformatf("oor_cfg%0d", ch), ch, 0, 8'h0);
         b_rd_chk($sformatf("oor_val%0d", ch), ch, 1, 8'hFF);
      end
      step();
      chk("oor_pend", 64'(b_irq_pend), 64'h0);
      b_wr_en = 1'b1; b_wr_ch = 2'd2; b_wr_sel = 2'd0; b_wr_data = 8'h05; b_wr_mask = 8'hFF;
      step();
      b_wr_en = 1'b0;
      b_rd_chk("inr_val", 2, 1, 8'h4);
      b_rd_chk("oor_rd_cfg", 3, 0, 8'h0);
      b_rd_chk("oor_rd_val", 3, 1, 8'h0);

      // Randomized traffic against the reference model
      do_reset();
      for (int n = 0; n < 400; n++) begin
         reset   = ($urandom_range(0, 63) == 0);
         wr_en   = $urandom_range(0, 1) == 1;
         wr_ch   = 2'($urandom_range(0, 3));
         wr_sel  = 2'($urandom_range(0, 3));
         wr_data = ($urandom_range(0, 3) != 0) ? 32'($urandom_range(0, 31)) : 32'($urandom);
         wr_mask = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'($urandom);
         irq_en  = 4'($urandom_range(0, 15));
         step();
         rd_ch  = 2'($urandom_range(0, 3));
         rd_sel = 2'($urandom_range(0, 3));
         #1;
         chk("rand_rd", 64'(rd_data),
             64'((rd_sel == 2'd0) ? m_cfg[rd_ch] : (rd_sel == 2'd1) ? m_cnt[rd_ch] : 32'd0));
         chk("rand_pend", 64'(irq_pend), 64'(m_pend));
         chk("rand_irq", 64'(irq), 64'(|(m_pend & irq_en)));
         chk("rand_stable", stable_cnt, m_stable);
      end
      reset = 1'b0;
      wr_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
